// File: rtl/soric_inter_pkg.sv
// Shared defaults for the soric write interconnect: widths, slave decode
// constants and small helpers used by the top and its arbiters.
package soric_inter_pkg;

  localparam int unsigned INTER_DATA_WIDTH   = 32;
  localparam int unsigned INTER_M_ADDR_WIDTH = 11;
  localparam int unsigned INTER_S_ADDR_WIDTH = 10;
  localparam int unsigned INTER_WOMASTERS    = 2;
  localparam int unsigned INTER_WOSLAVES     = 2;

  // Field i (bits [i*M_ADDR_WIDTH +: M_ADDR_WIDTH]) belongs to slave i:
  // slave 0 takes addr[10] == 0, slave 1 takes addr[10] == 1.
  localparam logic [21:0] INTER_M_ADDR_MATCH = 22'h200000;
  localparam logic [21:0] INTER_M_ADDR_MASK  = 22'h200400;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inter_write_rr_arb.sv
// Round-robin arbiter for one write slave. A stalled winner stays locked
// until its handshake or until it withdraws its request.
module inter_write_rr_arb
  import soric_inter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         slave_gnt,
  output logic         valid,
  output logic [N-1:0] grant
);

  localparam int IDX_W = idx_width(N);

  logic [IDX_W-1:0] last_grant_r;
  logic [IDX_W-1:0] lock_idx_r;
  logic             lock_r;
  logic [IDX_W-1:0] rr_idx_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             hold_s;

  // Lowest requester above last_grant wins, wrapping to the lowest overall.
  always_comb begin
    rr_idx_s = '0;
    for (int j = N - 1; j >= 0; j--) begin
      rr_idx_s = req[j] ? IDX_W'(j) : rr_idx_s;
    end
    for (int j = N - 1; j >= 0; j--) begin
      rr_idx_s = (req[j] && (IDX_W'(j) > last_grant_r)) ? IDX_W'(j) : rr_idx_s;
    end
  end

  // Locked master keeps the slave while it still requests.
  always_comb begin
    hold_s    = lock_r & req[lock_idx_r];
    win_idx_s = hold_s ? lock_idx_r : rr_idx_s;
    valid     = |req;
    for (int j = 0; j < N; j++) begin
      grant[j] = valid & (win_idx_s == IDX_W'(j));
    end
  end

  // Pointer advances on handshake only; a stall locks the current winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= IDX_W'(N - 1);
      lock_idx_r   <= '0;
      lock_r       <= 1'b0;
    end else if (valid && slave_gnt) begin
      last_grant_r <= win_idx_s;
      lock_r       <= 1'b0;
    end else if (valid) begin
      lock_idx_r   <= win_idx_s;
      lock_r       <= 1'b1;
    end else begin
      lock_r       <= 1'b0;
    end
  end

endmodule

// File: rtl/inter_write.sv
// Write-only crossbar: decodes master addresses onto slaves, arbitrates per
// slave and answers unmapped writes locally with an error response.
module inter_write
  import soric_inter_pkg::*;
#(
  parameter int DATA_WIDTH   = INTER_DATA_WIDTH,
  parameter int M_ADDR_WIDTH = INTER_M_ADDR_WIDTH,
  parameter int S_ADDR_WIDTH = INTER_S_ADDR_WIDTH,
  parameter int WOMASTERS    = INTER_WOMASTERS,
  parameter int WOSLAVES     = INTER_WOSLAVES,
  parameter logic [WOSLAVES*M_ADDR_WIDTH-1:0] M_ADDR_MATCH = INTER_M_ADDR_MATCH,
  parameter logic [WOSLAVES*M_ADDR_WIDTH-1:0] M_ADDR_MASK  = INTER_M_ADDR_MASK
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [WOMASTERS-1:0]               master_data_req_i,
  input  logic [WOMASTERS*M_ADDR_WIDTH-1:0]  master_data_addr_i,
  input  logic [WOMASTERS*DATA_WIDTH-1:0]    master_data_wdata_i,
  input  logic [WOMASTERS*DATA_WIDTH/8-1:0]  master_data_be_i,
  output logic [WOMASTERS-1:0]               master_data_gnt_o,
  output logic [WOMASTERS-1:0]               master_data_rvalid_o,
  output logic [WOMASTERS-1:0]               master_data_err_o,
  output logic [WOSLAVES-1:0]                slave_data_req_o,
  output logic [WOSLAVES-1:0]                slave_data_we_o,
  output logic [WOSLAVES*S_ADDR_WIDTH-1:0]   slave_data_addr_o,
  output logic [WOSLAVES*DATA_WIDTH-1:0]     slave_data_wdata_o,
  output logic [WOSLAVES*DATA_WIDTH/8-1:0]   slave_data_be_o,
  input  logic [WOSLAVES-1:0]                slave_data_gnt_i
);

  localparam int SIDX_W = idx_width(WOSLAVES);
  localparam int BE_W   = DATA_WIDTH / 8;

  logic [WOSLAVES-1:0]  hit_s     [WOMASTERS];
  logic [SIDX_W-1:0]    sel_s     [WOMASTERS];
  logic [WOMASTERS-1:0] slv_req_s [WOSLAVES];
  logic [WOMASTERS-1:0] slv_grant_s [WOSLAVES];
  logic [WOSLAVES-1:0]  slv_valid_s;
  logic [WOMASTERS-1:0] mapped_s;
  logic [WOMASTERS-1:0] unmapped_s;
  logic [WOMASTERS-1:0] gnt_s;
  logic [WOMASTERS-1:0] rvalid_r;
  logic [WOMASTERS-1:0] err_r;

  for (genvar j = 0; j < WOMASTERS; j++) begin : g_hit
    for (genvar i = 0; i < WOSLAVES; i++) begin : g_slv
      assign hit_s[j][i] =
        (master_data_addr_i[j*M_ADDR_WIDTH +: M_ADDR_WIDTH] & M_ADDR_MASK[i*M_ADDR_WIDTH +: M_ADDR_WIDTH])
        == M_ADDR_MATCH[i*M_ADDR_WIDTH +: M_ADDR_WIDTH];
    end
  end

  // Descending scan so the lowest matching slave wins on overlap.
  always_comb begin
    for (int j = 0; j < WOMASTERS; j++) begin
      sel_s[j]    = '0;
      mapped_s[j] = |hit_s[j];
      for (int i = WOSLAVES - 1; i >= 0; i--) begin
        sel_s[j] = hit_s[j][i] ? SIDX_W'(i) : sel_s[j];
      end
    end
    unmapped_s = master_data_req_i & ~mapped_s;
    for (int i = 0; i < WOSLAVES; i++) begin
      for (int j = 0; j < WOMASTERS; j++) begin
        slv_req_s[i][j] = master_data_req_i[j] & mapped_s[j] & (sel_s[j] == SIDX_W'(i));
      end
    end
  end

  for (genvar i = 0; i < WOSLAVES; i++) begin : g_arb
    inter_write_rr_arb #(.N(WOMASTERS)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (slv_req_s[i]),
      .slave_gnt (slave_data_gnt_i[i]),
      .valid     (slv_valid_s[i]),
      .grant     (slv_grant_s[i])
    );
  end

  // One-hot AND-OR mux of the winner onto each slave port; zero when idle.
  always_comb begin
    slave_data_addr_o  = '0;
    slave_data_wdata_o = '0;
    slave_data_be_o    = '0;
    gnt_s              = unmapped_s;
    for (int i = 0; i < WOSLAVES; i++) begin
      for (int j = 0; j < WOMASTERS; j++) begin
        slave_data_addr_o[i*S_ADDR_WIDTH +: S_ADDR_WIDTH] = slave_data_addr_o[i*S_ADDR_WIDTH +: S_ADDR_WIDTH]
          | ({S_ADDR_WIDTH{slv_grant_s[i][j]}} & master_data_addr_i[j*M_ADDR_WIDTH +: S_ADDR_WIDTH]);
        slave_data_wdata_o[i*DATA_WIDTH +: DATA_WIDTH] = slave_data_wdata_o[i*DATA_WIDTH +: DATA_WIDTH]
          | ({DATA_WIDTH{slv_grant_s[i][j]}} & master_data_wdata_i[j*DATA_WIDTH +: DATA_WIDTH]);
        slave_data_be_o[i*BE_W +: BE_W] = slave_data_be_o[i*BE_W +: BE_W]
          | ({BE_W{slv_grant_s[i][j]}} & master_data_be_i[j*BE_W +: BE_W]);
        gnt_s[j] = gnt_s[j] | (slave_data_gnt_i[i] & slv_grant_s[i][j]);
      end
    end
  end

  assign slave_data_req_o     = slv_valid_s;
  assign slave_data_we_o      = slv_valid_s;
  assign master_data_gnt_o    = gnt_s;
  assign master_data_rvalid_o = rvalid_r;
  assign master_data_err_o    = err_r;

  // Response one cycle after every grant; err marks locally-answered writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_r <= '0;
      err_r    <= '0;
    end else begin
      rvalid_r <= gnt_s;
      err_r    <= unmapped_s;
    end
  end

endmodule

// File: tb/tb_inter_write.sv
// Directed bench for inter_write: default decode instance plus one instance
// with a decode map that leaves 0x7FF unmapped.
module tb_inter_write;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  m_req, m_gnt, m_rvalid, m_err;
  logic [21:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_be;
  logic [1:0]  s_req, s_we, s_gnt;
  logic [19:0] s_addr;
  logic [63:0] s_wdata;
  logic [7:0]  s_be;

  logic [1:0]  c_req, c_gnt, c_rvalid, c_err;
  logic [21:0] c_addr;
  logic [63:0] c_wdata;
  logic [7:0]  c_be;
  logic [1:0]  c_sreq, c_swe, c_sgnt;
  logic [19:0] c_saddr;
  logic [63:0] c_swdata;
  logic [7:0]  c_sbe;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_gnt;
  logic [1:0] prev_gnt;

  inter_write u_dut (
    .clk(clk), .reset(reset),
    .master_data_req_i(m_req), .master_data_addr_i(m_addr),
    .master_data_wdata_i(m_wdata), .master_data_be_i(m_be),
    .master_data_gnt_o(m_gnt), .master_data_rvalid_o(m_rvalid), .master_data_err_o(m_err),
    .slave_data_req_o(s_req), .slave_data_we_o(s_we), .slave_data_addr_o(s_addr),
    .slave_data_wdata_o(s_wdata), .slave_data_be_o(s_be), .slave_data_gnt_i(s_gnt)
  );

  inter_write #(
    .M_ADDR_MATCH({11'h400, 11'h000}),
    .M_ADDR_MASK ({11'h7FF, 11'h400})
  ) u_dut_c (
    .clk(clk), .reset(reset),
    .master_data_req_i(c_req), .master_data_addr_i(c_addr),
    .master_data_wdata_i(c_wdata), .master_data_be_i(c_be),
    .master_data_gnt_o(c_gnt), .master_data_rvalid_o(c_rvalid), .master_data_err_o(c_err),
    .slave_data_req_o(c_sreq), .slave_data_we_o(c_swe), .slave_data_addr_o(c_saddr),
    .slave_data_wdata_o(c_swdata), .slave_data_be_o(c_sbe), .slave_data_gnt_i(c_sgnt)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [10:0] a0, input logic [10:0] a1,
                       input logic [1:0] gnt);
    m_req   = req;
    m_addr  = {a1, a0};
    m_wdata = {32'hB000_0000 | {21'd0, a1}, 32'hA000_0000 | {21'd0, a0}};
    m_be    = {4'h3, 4'hF};
    s_gnt   = gnt;
  endtask

  initial begin
    reset   = 1'b1;
    drive(2'b00, 11'h000, 11'h000, 2'b00);
    c_req   = 2'b00;
    c_addr  = 22'd0;
    c_wdata = 64'd0;
    c_be    = 8'hFF;
    c_sgnt  = 2'b00;
    next_cycle();
    next_cycle();
    #2;
    check_value("rst_rvalid", 64'(m_rvalid), 64'd0);
    check_value("rst_err", 64'(m_err), 64'd0);
    check_value("rst_c_rvalid", 64'(c_rvalid), 64'd0);
    reset = 1'b0;

    // Two masters on slave 0: M0 first, M1 next cycle
    next_cycle();
    drive(2'b11, 11'h004, 11'h008, 2'b01);
    #2;
    check_value("rr0_gnt", 64'(m_gnt), 64'd1);
    check_value("rr0_sreq", 64'(s_req), 64'd1);
    check_value("rr0_swe", 64'(s_we), 64'd1);
    check_value("rr0_saddr", 64'(s_addr[9:0]), 64'h004);
    check_value("rr0_swdata", 64'(s_wdata[31:0]), 64'hA000_0004);
    check_value("rr0_sbe", 64'(s_be[3:0]), 64'hF);
    check_value("rr0_rvalid", 64'(m_rvalid), 64'd0);
    next_cycle();
    drive(2'b10, 11'h004, 11'h008, 2'b01);
    #2;
    check_value("rr1_gnt", 64'(m_gnt), 64'd2);
    check_value("rr1_saddr", 64'(s_addr[9:0]), 64'h008);
    check_value("rr1_swdata", 64'(s_wdata[31:0]), 64'hB000_0008);
    check_value("rr1_sbe", 64'(s_be[3:0]), 64'h3);
    check_value("rr1_rvalid", 64'(m_rvalid), 64'd1);
    next_cycle();
    drive(2'b00, 11'h004, 11'h008, 2'b01);
    #2;
    check_value("rr2_rvalid", 64'(m_rvalid), 64'd2);
    check_value("rr2_err", 64'(m_err), 64'd0);
    check_value("idle_gnt", 64'(m_gnt), 64'd0);
    check_value("idle_sreq", 64'(s_req), 64'd0);
    check_value("idle_saddr", 64'(s_addr), 64'd0);
    check_value("idle_swdata", 64'(s_wdata), 64'd0);

    // M1 stalled on slave 0; M0 arriving later must not preempt it
    next_cycle();
    drive(2'b10, 11'h030, 11'h020, 2'b00);
    #2;
    check_value("lock0_gnt", 64'(m_gnt), 64'd0);
    check_value("lock0_sreq", 64'(s_req), 64'd1);
    check_value("lock0_saddr", 64'(s_addr[9:0]), 64'h020);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      drive(2'b11, 11'h030, 11'h020, 2'b00);
      #2;
      check_value("lock_hold_saddr", 64'(s_addr[9:0]), 64'h020);
      check_value("lock_hold_gnt", 64'(m_gnt), 64'd0);
      check_value("lock_hold_rvalid", 64'(m_rvalid), 64'd0);
    end
    next_cycle();
    drive(2'b11, 11'h030, 11'h020, 2'b01);
    #2;
    check_value("lock_rel_gnt", 64'(m_gnt), 64'd2);
    check_value("lock_rel_saddr", 64'(s_addr[9:0]), 64'h020);
    next_cycle();
    drive(2'b01, 11'h030, 11'h020, 2'b01);
    #2;
    check_value("lock_next_gnt", 64'(m_gnt), 64'd1);
    check_value("lock_next_saddr", 64'(s_addr[9:0]), 64'h030);
    check_value("lock_next_rvalid", 64'(m_rvalid), 64'd2);
    next_cycle();
    drive(2'b00, 11'h000, 11'h000, 2'b00);
    #2;
    check_value("lock_end_rvalid", 64'(m_rvalid), 64'd1);

    // Different slaves granted together
    next_cycle();
    drive(2'b11, 11'h010, 11'h410, 2'b11);
    #2;
    check_value("par_gnt", 64'(m_gnt), 64'd3);
    check_value("par_sreq", 64'(s_req), 64'd3);
    check_value("par_s1addr", 64'(s_addr[19:10]), 64'h010);
    check_value("par_s0addr", 64'(s_addr[9:0]), 64'h010);
    check_value("par_s1wdata", 64'(s_wdata[63:32]), 64'hB000_0410);
    next_cycle();
    drive(2'b00, 11'h000, 11'h000, 2'b00);
    #2;
    check_value("par_rvalid", 64'(m_rvalid), 64'd3);
    check_value("par_err", 64'(m_err), 64'd0);

    // Reset while M0 is locked and stalled on slave 0
    next_cycle();
    drive(2'b11, 11'h044, 11'h404, 2'b10);
    #2;
    check_value("pre_rst_gnt", 64'(m_gnt), 64'd2);
    check_value("pre_rst_sreq", 64'(s_req), 64'd3);
    next_cycle();
    drive(2'b01, 11'h044, 11'h404, 2'b10);
    #2;
    check_value("pre_rst_rvalid", 64'(m_rvalid), 64'd2);
    check_value("stall_gnt", 64'(m_gnt), 64'd0);
    reset = 1'b1;
    #1;
    check_value("async_rst_rvalid", 64'(m_rvalid), 64'd0);
    next_cycle();
    drive(2'b11, 11'h100, 11'h200, 2'b00);
    #2;
    check_value("in_rst_rvalid", 64'(m_rvalid), 64'd0);

    // After reset: continuous contention alternates starting at M0
    prev_gnt = 2'b00;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      reset = 1'b0;
      drive(2'b11, 11'h100, 11'h200, 2'b01);
      #2;
      exp_gnt = ((k % 2) == 0) ? 2'b01 : 2'b10;
      check_value("alt_gnt", 64'(m_gnt), 64'(exp_gnt));
      check_value("alt_rvalid", 64'(m_rvalid), 64'(prev_gnt));
      prev_gnt = exp_gnt;
    end
    next_cycle();
    drive(2'b00, 11'h000, 11'h000, 2'b00);
    #2;
    check_value("alt_last_rvalid", 64'(m_rvalid), 64'd2);

    // Unmapped write on the custom-decode instance
    next_cycle();
    c_req  = 2'b11;
    c_addr = {11'h123, 11'h7FF};
    c_sgnt = 2'b01;
    #2;
    check_value("unm_gnt", 64'(c_gnt), 64'd3);
    check_value("unm_sreq", 64'(c_sreq), 64'd1);
    check_value("unm_saddr", 64'(c_saddr[9:0]), 64'h123);
    check_value("unm_rvalid0", 64'(c_rvalid), 64'd0);
    next_cycle();
    c_req  = 2'b01;
    c_sgnt = 2'b00;
    #2;
    check_value("unm_rvalid", 64'(c_rvalid), 64'd3);
    check_value("unm_err", 64'(c_err), 64'd1);
    check_value("unm_sreq_only", 64'(c_sreq), 64'd0);
    check_value("unm_gnt_again", 64'(c_gnt), 64'd1);
    next_cycle();
    c_req = 2'b00;
    #2;
    check_value("unm_err2", 64'(c_err), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inter_write.md
INTER_WRITE -- requirements
Module: inter_write

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter M_ADDR_WIDTH, default 11, master address width.
REQ-003 SHALL have parameter S_ADDR_WIDTH, default 10, slave address width; slave address = low S_ADDR_WIDTH master address bits.
REQ-004 SHALL have parameter WOMASTERS, default 2, number of write masters.
REQ-005 SHALL have parameter WOSLAVES, default 2, number of write slaves.
REQ-006 SHALL have parameters M_ADDR_MATCH, default 22'h200000, and M_ADDR_MASK, default 22'h200400, one M_ADDR_WIDTH field per slave.
REQ-007 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have master_data_req_i, input, WOMASTERS, write request per master.
REQ-010 SHALL have master_data_addr_i, input, WOMASTERS*M_ADDR_WIDTH, packed write addresses.
REQ-011 SHALL have master_data_wdata_i, input, WOMASTERS*DATA_WIDTH, packed write data.
REQ-012 SHALL have master_data_be_i, input, WOMASTERS*DATA_WIDTH/8, byte enables.
REQ-013 SHALL have master_data_gnt_o, output, WOMASTERS, write accepted this cycle.
REQ-014 SHALL have master_data_rvalid_o, output, WOMASTERS, write response, one cycle after gnt.
REQ-015 SHALL have master_data_err_o, output, WOMASTERS, qualifies rvalid; 1 = unmapped address.
REQ-016 SHALL have slave_data_req_o, output, WOSLAVES; slave_data_we_o, output, WOSLAVES, equal to req.
REQ-017 SHALL have slave_data_addr_o (WOSLAVES*S_ADDR_WIDTH), slave_data_wdata_o (WOSLAVES*DATA_WIDTH), slave_data_be_o (WOSLAVES*DATA_WIDTH/8), all outputs.
REQ-018 SHALL have slave_data_gnt_i, input, WOSLAVES, slave accepts write.

Function
REQ-019 Decode: master j targets slave i when (addr_j & MASK_i) == MATCH_i; multiple matches resolve to lowest i.
REQ-020 Master with req and no match SHALL get gnt same cycle, rvalid and err next cycle, no slave request.
REQ-021 Each slave SHALL have a round-robin arbiter; priority starts at master (last_grant+1) mod WOMASTERS.
REQ-022 last_grant SHALL update to winning master only on handshake (slave_data_req_o & slave_data_gnt_i).
REQ-023 Lock: when slave_data_req_o=1 and slave_data_gnt_i=0, winner SHALL be held next cycle while its request stays asserted; a newly arriving request SHALL NOT preempt.
REQ-024 Lock SHALL clear on handshake or when held master drops req.
REQ-025 Slave outputs SHALL mux addr/wdata/be of winner; all zero when no winner.
REQ-026 master_data_gnt_o[j] = slave_data_gnt_i[i] & winner==j & req_j, combinational, zero-latency.
REQ-027 master_data_rvalid_o and master_data_err_o SHALL be registered copies of gnt / unmapped-gnt, exactly one cycle later.
REQ-028 Back-to-back: master holding req with gnt every cycle SHALL see rvalid every cycle.
REQ-029 Masters targeting different slaves SHALL be granted in the same cycle.

Reset
REQ-030 On reset: last_grant = WOMASTERS-1 (master 0 first), lock cleared, rvalid_o=0, err_o=0.
REQ-031 Reset mid-transfer SHALL drop the pending lock; no rvalid for aborted cycle.

Structure
REQ-032 Default widths and MATCH/MASK constants SHALL live in shared package soric_inter_pkg.
REQ-033 Per-slave arbitration (pointer, lock, grant) SHALL be sub-module inter_write_rr_arb, instantiated WOSLAVES times.

Verification
REQ-034 M0,M1 req addr 0x004 and 0x008, gnt_i[0]=1 -> M0 granted cycle 0, M1 cycle 1, rvalid M0 cycle 1, M1 cycle 2.
REQ-035 M0 addr 0x010, M1 addr 0x410 same cycle, gnt_i=2'b11 -> both gnt same cycle, slave1 addr 0x010.
REQ-036 M1 req slave0, gnt_i[0]=0 three cycles, M0 requests cycle 1 -> slave0 stays on M1 until gnt, then M0.
REQ-037 Both masters continuous to slave0 for 6 cycles, gnt_i=1 -> grants alternate 0,1,0,1,0,1.
REQ-038 Reset asserted while M0 locked and stalled -> rvalid_o=0 immediately, next arbitration starts at M0.
REQ-039 Custom MATCH/MASK leaving address 0x7FF unmapped, M0 writes 0x7FF -> gnt same cycle, rvalid=1, err=1 next cycle, slave_data_req_o=0.
